// File: rtl/axi_slave_rd_arbiter_pkg.sv
// Shared types for the two-master AXI4 read arbiter: bus widths, master indices, FSM states.
// The AXI_RD_ARB_FIXED_PRIO_EN build option is consumed by rr_arbiter2, not here.
package axi_arb_pkg;

   localparam int AXI_ID_BITS   = 4;
   localparam int AXI_IDS_BITS  = 8;
   localparam int AXI_ADDR_BITS = 32;
   localparam int AXI_LEN_BITS  = 4;
   localparam int AXI_SIZE_BITS = 3;
   localparam int AXI_DATA_BITS = 32;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_e;

   // Slave-side ID carries the granted master index in the upper nibble.
   function automatic logic [AXI_IDS_BITS-1:0] widen_id(input logic idx,
                                                        input logic [AXI_ID_BITS-1:0] id);
      return {4'(idx), id};
   endfunction

endpackage

// File: rtl/axi_slave_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) with a configurable ID width.
// Every channel follows strict valid/ready: a transfer occurs on the ACLK edge where VALID and READY
// are both high; the source holds VALID and payload stable until then, and READY may depend on VALID.
interface axi_slave_rd_arbiter_if
   import axi_arb_pkg::*;
   #(parameter int ID_W = AXI_ID_BITS) ();

   logic [ID_W-1:0]          ARID;
   logic [AXI_ADDR_BITS-1:0] ARADDR;
   logic [AXI_LEN_BITS-1:0]  ARLEN;
   logic [AXI_SIZE_BITS-1:0] ARSIZE;
   logic [1:0]               ARBURST;
   logic                     ARVALID;
   logic                     ARREADY;

   logic [ID_W-1:0]          RID;
   logic [AXI_DATA_BITS-1:0] RDATA;
   logic [1:0]               RRESP;
   logic                     RLAST;
   logic                     RVALID;
   logic                     RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

endinterface

// File: rtl/axi_slave_rd_arbiter_rr_arbiter2.sv
// Two-request arbiter: round-robin on last_grant by default, fixed M1 priority when
// AXI_RD_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
   logic last_grant_unused;
   assign last_grant_unused = last_grant;

   always_comb begin
      grant_valid = |req;
      grant       = req[M1] ? M1 : M0;
   end
`else
   always_comb begin
      grant_valid = |req;
      grant       = M0;
      case (req)
         2'b01:   grant = M0;
         2'b10:   grant = M1;
         2'b11:   grant = ~last_grant;
         default: grant = M0;
      endcase
   end
`endif

endmodule

// File: rtl/axi_slave_rd_arbiter.sv
// Two-master AXI4 read arbiter: one burst in flight, AR payload latched, R steered to the owner.
// Arbitration policy is selected by AXI_RD_ARB_FIXED_PRIO_EN (see rr_arbiter2).
module axi_slave_rd_arbiter
   import axi_arb_pkg::*;
(
   input  logic                    ACLK,
   input  logic                    ARESETn,
   axi_slave_rd_arbiter_if.slave   m0,
   axi_slave_rd_arbiter_if.slave   m1,
   axi_slave_rd_arbiter_if.master  s,
   output state_e                  dbg_state
);

   state_e                   state_q, state_d;
   logic                     owner_q;
   logic                     last_grant_q;
   logic [AXI_IDS_BITS-1:0]  arid_q;
   logic [AXI_ADDR_BITS-1:0] araddr_q;
   logic [AXI_LEN_BITS-1:0]  arlen_q;
   logic [AXI_SIZE_BITS-1:0] arsize_q;
   logic [1:0]               arburst_q;

   logic grant, grant_valid;
   logic ar_hs, r_last_hs, owner_rready;
   logic [3:0] rid_hi_unused;

   assign rid_hi_unused = s.RID[7:4];
   assign dbg_state     = state_q;

   rr_arbiter2 u_arb (
      .req         ({m1.ARVALID, m0.ARVALID}),
      .last_grant  (last_grant_q),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign ar_hs        = (state_q == IDLE) && grant_valid;
   assign owner_rready = (owner_q == M1) ? m1.RREADY : m0.RREADY;
   // ARLEN is never counted: RLAST alone closes the burst.
   assign r_last_hs    = (state_q == DATA) && s.RVALID && owner_rready && s.RLAST;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q      <= IDLE;
         owner_q      <= M0;
         last_grant_q <= M1;
         arid_q       <= '0;
         araddr_q     <= '0;
         arlen_q      <= '0;
         arsize_q     <= '0;
         arburst_q    <= '0;
      end else begin
         state_q <= state_d;
         if (ar_hs) begin
            owner_q   <= grant;
            arid_q    <= widen_id(grant, (grant == M1) ? m1.ARID : m0.ARID);
            araddr_q  <= (grant == M1) ? m1.ARADDR  : m0.ARADDR;
            arlen_q   <= (grant == M1) ? m1.ARLEN   : m0.ARLEN;
            arsize_q  <= (grant == M1) ? m1.ARSIZE  : m0.ARSIZE;
            arburst_q <= (grant == M1) ? m1.ARBURST : m0.ARBURST;
         end
         if (r_last_hs) last_grant_q <= owner_q;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_valid) state_d = ADDR;
         ADDR:    if (s.ARREADY)   state_d = DATA;
         DATA:    if (r_last_hs)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s.ARID    = arid_q;
      s.ARADDR  = araddr_q;
      s.ARLEN   = arlen_q;
      s.ARSIZE  = arsize_q;
      s.ARBURST = arburst_q;
      s.ARVALID = (state_q == ADDR);
      s.RREADY  = 1'b0;

      m0.ARREADY = (state_q == IDLE) && grant_valid && (grant == M0);
      m1.ARREADY = (state_q == IDLE) && grant_valid && (grant == M1);

      m0.RVALID = 1'b0;  m0.RID = '0;  m0.RDATA = '0;  m0.RRESP = '0;  m0.RLAST = 1'b0;
      m1.RVALID = 1'b0;  m1.RID = '0;  m1.RDATA = '0;  m1.RRESP = '0;  m1.RLAST = 1'b0;

      // Zero-latency R path: only the owner sees the slave beats.
      if (state_q == DATA) begin
         s.RREADY = owner_rready;
         if (owner_q == M0) begin
            m0.RVALID = s.RVALID;
            m0.RID    = s.RID[3:0];
            m0.RDATA  = s.RDATA;
            m0.RRESP  = s.RRESP;
            m0.RLAST  = s.RLAST;
         end else begin
            m1.RVALID = s.RVALID;
            m1.RID    = s.RID[3:0];
            m1.RDATA  = s.RDATA;
            m1.RRESP  = s.RRESP;
            m1.RLAST  = s.RLAST;
         end
      end
   end

endmodule

// File: tb/tb_axi_slave_rd_arbiter.sv
// Directed bench for axi_slave_rd_arbiter with a transaction-level model checked every cycle
// and an expected-grant queue; honours AXI_RD_ARB_FIXED_PRIO_EN.
module tb_axi_slave_rd_arbiter;
   import axi_arb_pkg::*;

   logic   ACLK;
   logic   ARESETn;
   state_e dbg_state;

   axi_slave_rd_arbiter_if #(.ID_W(AXI_ID_BITS))  m0_if ();
   axi_slave_rd_arbiter_if #(.ID_W(AXI_ID_BITS))  m1_if ();
   axi_slave_rd_arbiter_if #(.ID_W(AXI_IDS_BITS)) s_if ();

   axi_slave_rd_arbiter dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .m0        (m0_if),
      .m1        (m1_if),
      .s         (s_if),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;
   bit checking = 1'b0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s act=timeout exp=event t=%0t", name, $time);
   endtask

   // ---------------- model: one burst in flight, owner-steered R ----------------
   int         md_phase = 0;  // 0 waiting for a request, 1 address offered, 2 data returning
   int         md_owner = 0;
   int         md_last  = 1;
   logic [7:0] md_id    = '0;
   logic [31:0] md_addr = '0;
   logic [3:0] md_len   = '0;
   logic [2:0] md_size  = '0;
   logic [1:0] md_burst = '0;

   function automatic int md_winner();
      bit v0 = m0_if.ARVALID;
      bit v1 = m1_if.ARVALID;
      if (v0 && v1) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
         return 1;
`else
         return (md_last == 1) ? 0 : 1;
`endif
      end
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         md_phase = 0;
         md_owner = 0;
         md_last  = 1;
      end else begin
         case (md_phase)
            0: begin
               int w;
               w = md_winner();
               if (w >= 0) begin
                  md_owner = w;
                  md_id    = 8'(w * 16) + ((w == 1) ? 8'(m1_if.ARID) : 8'(m0_if.ARID));
                  md_addr  = (w == 1) ? m1_if.ARADDR  : m0_if.ARADDR;
                  md_len   = (w == 1) ? m1_if.ARLEN   : m0_if.ARLEN;
                  md_size  = (w == 1) ? m1_if.ARSIZE  : m0_if.ARSIZE;
                  md_burst = (w == 1) ? m1_if.ARBURST : m0_if.ARBURST;
                  md_phase = 1;
               end
            end
            1: if (s_if.ARREADY) md_phase = 2;
            default: begin
               bit rr;
               rr = (md_owner == 1) ? m1_if.RREADY : m0_if.RREADY;
               if (s_if.RVALID && rr && s_if.RLAST) begin
                  md_phase = 0;
                  md_last  = md_owner;
               end
            end
         endcase
      end
   end

   task automatic chk_r(input string tag, input bit own, input logic rv, input logic [3:0] rid,
                        input logic [31:0] rdata, input logic [1:0] rresp, input logic rlast);
      chk({tag, "_rvalid"}, 32'(rv),    own ? 32'(s_if.RVALID)      : 32'd0);
      chk({tag, "_rid"},    32'(rid),   own ? 32'(s_if.RID % 8'd16) : 32'd0);
      chk({tag, "_rdata"},  rdata,      own ? s_if.RDATA            : 32'd0);
      chk({tag, "_rresp"},  32'(rresp), own ? 32'(s_if.RRESP)       : 32'd0);
      chk({tag, "_rlast"},  32'(rlast), own ? 32'(s_if.RLAST)       : 32'd0);
   endtask

   always @(negedge ACLK) begin
      if (checking) begin
         int     w;
         state_e exp_st;
         w      = (md_phase == 0) ? md_winner() : -1;
         exp_st = (md_phase == 0) ? IDLE : (md_phase == 1) ? ADDR : DATA;
         chk("state",      32'(dbg_state),     32'(exp_st));
         chk("arready_m0", 32'(m0_if.ARREADY), 32'(w == 0));
         chk("arready_m1", 32'(m1_if.ARREADY), 32'(w == 1));
         chk("arvalid_s",  32'(s_if.ARVALID),  32'(md_phase == 1));
         chk("rready_s",   32'(s_if.RREADY),
             (md_phase == 2) ? 32'((md_owner == 1) ? m1_if.RREADY : m0_if.RREADY) : 32'd0);
         if (md_phase == 1) begin
            chk("arid_s",    32'(s_if.ARID),    32'(md_id));
            chk("araddr_s",  s_if.ARADDR,       md_addr);
            chk("arlen_s",   32'(s_if.ARLEN),   32'(md_len));
            chk("arsize_s",  32'(s_if.ARSIZE),  32'(md_size));
            chk("arburst_s", 32'(s_if.ARBURST), 32'(md_burst));
         end
         chk_r("m0", (md_phase == 2) && (md_owner == 0), m0_if.RVALID, m0_if.RID, m0_if.RDATA,
               m0_if.RRESP, m0_if.RLAST);
         chk_r("m1", (md_phase == 2) && (md_owner == 1), m1_if.RVALID, m1_if.RID, m1_if.RDATA,
               m1_if.RRESP, m1_if.RLAST);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic clear_inputs();
      m0_if.ARVALID = 0; m0_if.ARID = '0; m0_if.ARADDR = '0; m0_if.ARLEN = '0;
      m0_if.ARSIZE = '0; m0_if.ARBURST = '0; m0_if.RREADY = 0;
      m1_if.ARVALID = 0; m1_if.ARID = '0; m1_if.ARADDR = '0; m1_if.ARLEN = '0;
      m1_if.ARSIZE = '0; m1_if.ARBURST = '0; m1_if.RREADY = 0;
      s_if.ARREADY = 0; s_if.RVALID = 0; s_if.RID = '0; s_if.RDATA = '0;
      s_if.RRESP = '0; s_if.RLAST = 0;
   endtask

   task automatic apply_reset();
      ARESETn = 1'b0;
      clear_inputs();
      tick();
      tick();
      ARESETn = 1'b1;
   endtask

   task automatic m_set(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [3:0] len);
      if (m == 0) begin
         m0_if.ARVALID = 1; m0_if.ARID = id; m0_if.ARADDR = addr; m0_if.ARLEN = len;
         m0_if.ARSIZE = 3'd2; m0_if.ARBURST = 2'b01;
      end else begin
         m1_if.ARVALID = 1; m1_if.ARID = id; m1_if.ARADDR = addr; m1_if.ARLEN = len;
         m1_if.ARSIZE = 3'd2; m1_if.ARBURST = 2'b01;
      end
   endtask

   task automatic m_drop(input int m);
      if (m == 0) m0_if.ARVALID = 0;
      else        m1_if.ARVALID = 0;
   endtask

   task automatic set_rready(input int m, input logic v);
      if (m == 0) m0_if.RREADY = v;
      else        m1_if.RREADY = v;
   endtask

   // Acts as the slave for one burst: accepts AR after `delay` extra cycles, returns ARLEN+1 beats.
   task automatic run_burst(input int delay, input bit toggle, input bit keep,
                            output logic [7:0] id, output logic [31:0] addr, output int lat,
                            output int hs, output logic [3:0] rid0, output bit leak);
      bit seen = 0;
      int own, nbeats, beat;
      id = '0; addr = '0; lat = 0; hs = 0; rid0 = '0; leak = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge ACLK);
         lat++;
         if (s_if.ARVALID) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         fail_timeout("ar_wait");
         return;
      end
      id     = s_if.ARID;
      addr   = s_if.ARADDR;
      nbeats = int'(s_if.ARLEN) + 1;
      own    = int'(id[4]);
      tick();
      if (!keep) m_drop(own);
      for (int d = 0; d < delay; d++) begin
         @(negedge ACLK);
         chk("ar_hold_valid", 32'(s_if.ARVALID), 32'd1);
         chk("ar_hold_id",    32'(s_if.ARID),    32'(id));
         chk("ar_hold_addr",  s_if.ARADDR,       addr);
         chk("ar_hold_noready", 32'(m0_if.ARREADY | m1_if.ARREADY), 32'd0);
         tick();
      end
      s_if.ARREADY = 1;
      tick();
      s_if.ARREADY = 0;
      beat = 0;
      for (int c = 0; c < 64 && beat < nbeats; c++) begin
         s_if.RVALID = 1;
         s_if.RID    = id;
         s_if.RDATA  = 32'hC0DE_0000 | (32'(id) << 8) | 32'(beat);
         s_if.RRESP  = 2'b00;
         s_if.RLAST  = (beat == nbeats - 1);
         set_rready(own, toggle ? (c % 2 == 0) : 1'b1);
         set_rready(1 - own, 1'b1);
         @(negedge ACLK);
         if ((own == 0) ? m1_if.RVALID : m0_if.RVALID) leak = 1;
         if (s_if.RREADY) begin
            if (hs == 0) rid0 = (own == 0) ? m0_if.RID : m1_if.RID;
            hs++;
            beat++;
         end
         tick();
      end
      if (beat < nbeats) fail_timeout("r_beats");
      s_if.RVALID = 0;
      s_if.RLAST  = 0;
      set_rready(0, 1'b0);
      set_rready(1, 1'b0);
   endtask

   task automatic check_grant(input string name, input logic [7:0] got);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         fail_timeout({name, "_no_expectation"});
         return;
      end
      e = exp_q.pop_front();
      chk(name, 32'(got), 32'(e));
   endtask

   // ---------------- directed tests ----------------
   initial begin
      logic [7:0]  id;
      logic [31:0] addr;
      logic [3:0]  rid0;
      int          lat, hs;
      bit          leak;
      bit          seen;

      ARESETn = 1'b0;
      clear_inputs();
      checking = 1'b1;
      @(negedge ACLK);
      chk("rst_state",     32'(dbg_state),      32'(IDLE));
      chk("rst_arvalid_s", 32'(s_if.ARVALID),   32'd0);
      chk("rst_arid_s",    32'(s_if.ARID),      32'd0);
      chk("rst_araddr_s",  s_if.ARADDR,         32'd0);
      chk("rst_rready_s",  32'(s_if.RREADY),    32'd0);
      chk("rst_rvalid_m0", 32'(m0_if.RVALID),   32'd0);
      chk("rst_rdata_m1",  m1_if.RDATA,         32'd0);
      m_set(0, 4'h3, 32'h0, 4'd0);
      #1;
      chk("rst_comb_grant_m0", 32'(m0_if.ARREADY), 32'd1);
      m_drop(0);
      apply_reset();

      // single M0 beat
      m_set(0, 4'h3, 32'h0000_0010, 4'd0);
      exp_q.push_back(8'h03);
      run_burst(0, 1'b0, 1'b0, id, addr, lat, hs, rid0, leak);
      check_grant("t1_arid_s", id);
      chk("t1_araddr_s", addr, 32'h0000_0010);
      chk("t1_ar_latency", 32'(lat), 32'd2);
      chk("t1_beats", 32'(hs), 32'd1);
      chk("t1_rid_m0", 32'(rid0), 32'h3);
      chk("t1_rvalid_m1_leak", 32'(leak), 32'd0);

      // simultaneous requests after reset
      apply_reset();
      m_set(0, 4'h5, 32'h0000_0100, 4'd0);
      m_set(1, 4'h9, 32'h0000_0200, 4'd0);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
      exp_q.push_back(8'h19);
      exp_q.push_back(8'h05);
`else
      exp_q.push_back(8'h05);
      exp_q.push_back(8'h19);
`endif
      run_burst(0, 1'b0, 1'b0, id, addr, lat, hs, rid0, leak);
      check_grant("t2_first_grant", id);
      run_burst(0, 1'b0, 1'b0, id, addr, lat, hs, rid0, leak);
      check_grant("t2_second_grant", id);
      chk("t2_second_latency", 32'(lat), 32'd2);

      // M1 4-beat burst with toggling RREADY
      m_set(1, 4'h7, 32'h0000_3000, 4'd3);
      exp_q.push_back(8'h17);
      run_burst(0, 1'b1, 1'b0, id, addr, lat, hs, rid0, leak);
      check_grant("t3_arid_s", id);
      chk("t3_handshakes", 32'(hs), 32'd4);
      chk("t3_rid_m1", 32'(rid0), 32'h7);
      chk("t3_rvalid_m0_leak", 32'(leak), 32'd0);
      @(negedge ACLK);
      chk("t3_idle_after_rlast", 32'(dbg_state), 32'(IDLE));
      tick();

      // slave stalls AR for 5 cycles while M1 keeps requesting
      m_set(1, 4'h2, 32'h4000_0040, 4'd1);
      exp_q.push_back(8'h12);
      run_burst(4, 1'b0, 1'b1, id, addr, lat, hs, rid0, leak);
      m_drop(1);
      check_grant("t4_arid_s", id);
      chk("t4_araddr_s", addr, 32'h4000_0040);
      chk("t4_beats", 32'(hs), 32'd2);
      tick();

      // asynchronous reset during beat 2 of 4
      m_set(0, 4'h6, 32'h0000_0500, 4'd3);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge ACLK);
         if (s_if.ARVALID) begin
            seen = 1;
            break;
         end
      end
      if (!seen) fail_timeout("t5_ar_wait");
      tick();
      m_drop(0);
      s_if.ARREADY = 1;
      tick();
      s_if.ARREADY = 0;
      s_if.RVALID = 1; s_if.RID = 8'h06; s_if.RDATA = 32'h1111_0000; s_if.RLAST = 0;
      set_rready(0, 1'b1);
      tick();
      s_if.RDATA = 32'h1111_0001;
      @(negedge ACLK);
      chk("t5_beat2_rvalid_m0", 32'(m0_if.RVALID), 32'd1);
      #2;
      ARESETn = 1'b0;
      #1;
      chk("t5_rst_state",     32'(dbg_state),    32'(IDLE));
      chk("t5_rst_arvalid_s", 32'(s_if.ARVALID), 32'd0);
      chk("t5_rst_rready_s",  32'(s_if.RREADY),  32'd0);
      chk("t5_rst_rvalid_m0", 32'(m0_if.RVALID), 32'd0);
      chk("t5_rst_rdata_m0",  m0_if.RDATA,       32'd0);
      chk("t5_rst_arid_s",    32'(s_if.ARID),    32'd0);
      clear_inputs();
      tick();
      tick();
      ARESETn = 1'b1;
      m_set(0, 4'h6, 32'h0000_0600, 4'd0);
      exp_q.push_back(8'h06);
      run_burst(0, 1'b0, 1'b0, id, addr, lat, hs, rid0, leak);
      check_grant("t5_after_reset_arid", id);
      chk("t5_after_reset_addr", addr, 32'h0000_0600);
      chk("t5_after_reset_beats", 32'(hs), 32'd1);

      // continuous requests from both masters, 8 bursts
      apply_reset();
      m_set(0, 4'h1, 32'h0000_7000, 4'd0);
      m_set(1, 4'hE, 32'h0000_8000, 4'd1);
      for (int i = 0; i < 8; i++) begin
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
         exp_q.push_back(8'h1E);
`else
         exp_q.push_back((i % 2 == 0) ? 8'h01 : 8'h1E);
`endif
      end
      for (int i = 0; i < 8; i++) begin
         run_burst(0, 1'b0, 1'b1, id, addr, lat, hs, rid0, leak);
         check_grant($sformatf("t6_grant%0d", i), id);
         if (i < 7) begin
            @(negedge ACLK);
            chk($sformatf("t6_gap%0d_arready", i), 32'(m0_if.ARREADY | m1_if.ARREADY), 32'd1);
         end
      end
      m_drop(0);
      m_drop(1);
      tick();
      tick();
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
